sys_timer_irq: RTL and testbench
================================

SYS_TIMER_IRQ -- requirements
Module: sys_timer_irq

Interface
REQ-001 clk  in  1  system clock; all logic on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ce  in  1  CPU-cycle enable, one clk wide; all bus accesses and timer ticks are qualified by ce.
REQ-004 cs  in  1  sys register window selected (CPU 0x2020-0x2027).
REQ-005 we  in  1  1 = write, 0 = read.
REQ-006 addr  in  3  register index within the window.
REQ-007 din  in  8  CPU write data.
REQ-008 dout  out  8  registered read data.
REQ-009 joy  in  8  buttons, active-high; bit order R,L,D,U,B,A,select,start = [0..7].
REQ-010 dma_done  in  1  level from the DMA engine, high when a transfer completes.
REQ-011 irq  out  1  level IRQ to CPU.
REQ-012 nmi  out  1  periodic NMI request.
REQ-013 lcd_en  out  1  sys_ctl[3].
REQ-014 bank  out  2  sys_ctl[6:5], cartridge bank select.

Function
REQ-015 An access occurs only when cs & ce; read effects apply only when we=0, write effects only when we=1.
REQ-016 Registers: 0 = joypad (R), 3 = timer count (R/W), 4 = timer ack (R), 5 = DMA ack (R), 6 = sys_ctl (R/W), 7 = irq status (R); other indices read 0xFF and ignore writes.
REQ-017 Reading register 0 returns ~joy.
REQ-018 dout updates on the clk edge of the read access and holds until the next read access; latency is 1 clk.
REQ-019 Prescaler: 14-bit down-counter, decremented on ce; at 0 it reloads 16383 if sys_ctl[4]=1, else 255, and asserts tick for that ce.
REQ-020 On tick, if timer>0, timer decrements; a 1->0 transition sets status[0].
REQ-021 A write to register 3 loads timer=din and restarts the prescaler from its reload value.
REQ-022 Writing 0 to register 3 sets status[0] on the same edge.
REQ-023 A write to register 3 and a tick in the same ce: the write wins and no decrement occurs.
REQ-024 Timer at 0 stays at 0; no repeated status set without a new write.
REQ-025 A read of register 4 clears status[0]; a read of register 5 clears status[1].
REQ-026 A rising edge of dma_done (registered previous value) sets status[1].
REQ-027 A set and an ack of the same status bit in the same clk: the set wins.
REQ-028 Register 7 reads {6'b0, status[1:0]}.
REQ-029 irq = (status[0] & sys_ctl[1]) | (status[1] & sys_ctl[2]), registered, 1-clk latency.
REQ-030 Clearing an enable bit deasserts irq within 1 clk without altering status.
REQ-031 NMI counter: 16-bit, increments on ce, wraps 0xFFFF->0; nmi=1 while count==0.

Reset
REQ-032 On reset: sys_ctl, timer, status, prescaler and NMI counter = 0; dma_done history = 0; dout = 0x00; irq = 0; nmi = 0; lcd_en = 0; bank = 0.
REQ-033 Reset mid-count abandons any pending tick; the first tick after reset occurs after 1 ce, then every 256 ce.

Configuration
REQ-034 Macro SYS_NMI_EN: defined -> NMI counter present per REQ-031; undefined -> counter omitted and nmi tied 0.

Verification
REQ-035 sys_ctl=0x02, write reg3=3, ce every clk -> status[0] and irq set after 3*256 ce (±1 ce), not earlier.
REQ-036 sys_ctl=0x12, write reg3=1 -> irq after 16384 ce; then read reg4 -> irq=0 next clk, reg7 reads 0x00.
REQ-037 sys_ctl=0x02, write reg3=0 -> irq=1 one clk later; timer reads 0.
REQ-038 sys_ctl=0x04, pulse dma_done -> reg7=0x02, irq=1; read reg5 in the same clk as a new dma_done edge -> status[1] stays 1.
REQ-039 joy=0x05 -> reg0 reads 0xFA; write reg6=0x68 -> lcd_en=1, bank=3, reg6 reads 0x68.
REQ-040 With SYS_NMI_EN, after reset -> nmi high for exactly 1 ce out of every 65536 ce; without it nmi=0 throughout.

Source files
------------

// File: rtl/sys_timer_irq.sv
// System register window: joypad, prescaled countdown timer, DMA-done latch, IRQ/NMI generation.
// Optional periodic NMI counter is built only when SYS_NMI_EN is defined; otherwise nmi is tied low.
module sys_timer_irq (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       cs,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] joy,
  input  logic       dma_done,
  output logic       irq,
  output logic       nmi,
  output logic       lcd_en,
  output logic [1:0] bank
);

  localparam int unsigned PRESC_W = 14;
  localparam int unsigned DATA_W  = 8;
  localparam logic [PRESC_W-1:0] RELOAD_FAST = PRESC_W'(255);
  localparam logic [PRESC_W-1:0] RELOAD_SLOW = PRESC_W'(16383);

  localparam logic [2:0] A_JOY    = 3'd0;
  localparam logic [2:0] A_TIMER  = 3'd3;
  localparam logic [2:0] A_TACK   = 3'd4;
  localparam logic [2:0] A_DACK   = 3'd5;
  localparam logic [2:0] A_CTL    = 3'd6;
  localparam logic [2:0] A_STATUS = 3'd7;

  logic [DATA_W-1:0]  r_ctl;
  logic [DATA_W-1:0]  r_timer;
  logic [1:0]         r_status;
  logic [PRESC_W-1:0] r_presc;
  logic               r_dma_prev;
  logic [DATA_W-1:0]  r_dout;
  logic               r_irq;

  logic               w_rd;
  logic               w_wr;
  logic               w_wr_timer;
  logic [PRESC_W-1:0] w_reload;
  logic [PRESC_W-1:0] w_presc_nxt;
  logic [DATA_W-1:0]  w_timer_nxt;
  logic [1:0]         w_set;
  logic [1:0]         w_clr;
  logic [1:0]         w_status_nxt;
  logic [DATA_W-1:0]  w_rdata;

  assign w_rd       = cs & ce & ~we;
  assign w_wr       = cs & ce & we;
  assign w_wr_timer = w_wr & (addr == A_TIMER);

  // Prescaler/timer next state; a timer write pre-empts a coincident tick.
  always_comb begin
    w_reload    = r_ctl[4] ? RELOAD_SLOW : RELOAD_FAST;
    w_presc_nxt = r_presc;
    w_timer_nxt = r_timer;
    w_set       = 2'b00;
    w_clr       = 2'b00;
    if (w_wr_timer) begin
      w_timer_nxt = din;
      w_presc_nxt = w_reload;
      w_set[0]    = (din == 8'd0);
    end else if (ce) begin
      if (r_presc == '0) begin
        w_presc_nxt = w_reload;
        if (r_timer != 8'd0) begin
          w_timer_nxt = r_timer - 8'd1;
          w_set[0]    = (r_timer == 8'd1);
        end
      end else begin
        w_presc_nxt = r_presc - PRESC_W'(1);
      end
    end
    w_set[1]     = dma_done & ~r_dma_prev;
    w_clr[0]     = w_rd & (addr == A_TACK);
    w_clr[1]     = w_rd & (addr == A_DACK);
    w_status_nxt = w_set | (r_status & ~w_clr);
  end

  always_comb begin
    w_rdata = 8'hFF;
    case (addr)
      A_JOY:                    w_rdata = ~joy;
      A_TIMER:                  w_rdata = r_timer;
      A_TACK, A_DACK, A_STATUS: w_rdata = {6'b0, r_status};
      A_CTL:                    w_rdata = r_ctl;
      default:                  w_rdata = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctl      <= '0;
      r_timer    <= '0;
      r_status   <= '0;
      r_presc    <= '0;
      r_dma_prev <= 1'b0;
      r_dout     <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_presc    <= w_presc_nxt;
      r_timer    <= w_timer_nxt;
      r_status   <= w_status_nxt;
      r_dma_prev <= dma_done;
      r_irq      <= (r_status[0] & r_ctl[1]) | (r_status[1] & r_ctl[2]);
      if (w_wr && addr == A_CTL) r_ctl <= din;
      if (w_rd) r_dout <= w_rdata;
    end
  end

  assign dout   = r_dout;
  assign irq    = r_irq;
  assign lcd_en = r_ctl[3];
  assign bank   = r_ctl[6:5];

`ifdef SYS_NMI_EN
  logic [15:0] r_nmi_cnt;
  logic        r_nmi;

  // nmi mirrors count==0, registered alongside the wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_nmi_cnt <= '0;
      r_nmi     <= 1'b0;
    end else if (ce) begin
      r_nmi_cnt <= r_nmi_cnt + 16'd1;
      r_nmi     <= (r_nmi_cnt == 16'hFFFF);
    end
  end

  assign nmi = r_nmi;
`else
  assign nmi = 1'b0;
`endif

endmodule

// File: tb/tb_sys_timer_irq.sv
// Directed scoreboard bench for sys_timer_irq; NMI checks follow SYS_NMI_EN.
module tb_sys_timer_irq;

  logic       clk = 1'b0;
  logic       reset, ce, cs, we, dma_done;
  logic [2:0] addr;
  logic [7:0] din, dout, joy;
  logic       irq, nmi, lcd_en;
  logic [1:0] bank;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  sys_timer_irq dut (
    .clk(clk), .reset(reset), .ce(ce), .cs(cs), .we(we), .addr(addr),
    .din(din), .dout(dout), .joy(joy), .dma_done(dma_done),
    .irq(irq), .nmi(nmi), .lcd_en(lcd_en), .bank(bank)
  );

  always #5 clk = ~clk;

  task automatic sb_push(input string tag, input logic [7:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic sb_check(input logic [7:0] obs);
    logic [7:0] e;
    string      t;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %h, no expectation queued", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] e);
    sb_push(tag, e);
    sb_check(obs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [7:0] e, input string tag);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a;
    sb_push(tag, e);
    @(posedge clk);
    #1;
    cs = 1'b0;
    sb_check(dout);
  endtask

  task automatic ack(input logic [2:0] a);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a;
    @(posedge clk);
    #1;
    cs = 1'b0;
  endtask

  task automatic wait_irq(input int max_n, output int n);
    n = 0;
    while (irq !== 1'b1 && n < max_n) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; ce = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; din = '0;
    joy = '0; dma_done = 1'b0;
    idle(2);
    check("rst_dout", dout, 8'h00);
    check("rst_irq", {7'b0, irq}, 8'h00);
    check("rst_nmi", {7'b0, nmi}, 8'h00);
    check("rst_lcd_bank", {5'b0, lcd_en, bank}, 8'h00);
    reset = 1'b0;

    // Joypad inversion, control register fields, unmapped index
    joy = 8'h05;
    bus_read(3'd0, 8'hFA, "joy_read");
    bus_write(3'd6, 8'h68);
    check("lcd_bank", {5'b0, lcd_en, bank}, 8'h07);
    bus_read(3'd6, 8'h68, "ctl_read");
    bus_read(3'd1, 8'hFF, "unmapped_read");
    bus_write(3'd2, 8'h00);
    @(negedge clk);
    ce = 1'b0; cs = 1'b1; we = 1'b1; addr = 3'd6; din = 8'h00;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0; ce = 1'b1;
    bus_read(3'd6, 8'h68, "ctl_ignores_no_ce");

    // Writing 0 to the timer raises status[0] immediately
    bus_write(3'd6, 8'h02);
    bus_write(3'd3, 8'h00);
    check("irq_reg_latency", {7'b0, irq}, 8'h00);
    idle(1);
    check("irq_after_zero_write", {7'b0, irq}, 8'h01);
    bus_read(3'd3, 8'h00, "timer_zero");
    bus_read(3'd7, 8'h01, "status_t0");
    ack(3'd4);
    idle(1);
    check("irq_cleared_ack4", {7'b0, irq}, 8'h00);
    bus_read(3'd7, 8'h00, "status_after_ack4");

    // Timer=3 at 256-ce prescale expires after ~768 ce
    bus_write(3'd3, 8'h03);
    wait_irq(900, n);
    $display("timer 3x256: irq after %0d clk", n);
    check("irq_delay_3x256", {7'b0, (irq === 1'b1 && n >= 768 && n <= 770)}, 8'h01);
    bus_read(3'd7, 8'h01, "status_3x256");
    ack(3'd4);
    idle(600);
    bus_read(3'd7, 8'h00, "no_resets_at_zero");

    // Slow prescaler, timer=1 expires after ~16384 ce
    bus_write(3'd6, 8'h12);
    bus_write(3'd3, 8'h01);
    wait_irq(16500, n);
    $display("timer 1x16384: irq after %0d clk", n);
    check("irq_delay_16384", {7'b0, (irq === 1'b1 && n >= 16384 && n <= 16386)}, 8'h01);
    ack(3'd4);
    idle(1);
    check("irq_drop_after_ack", {7'b0, irq}, 8'h00);
    bus_read(3'd7, 8'h00, "status_16384_ack");

    // Disabling the enable drops irq but keeps status
    bus_write(3'd3, 8'h00);
    idle(1);
    check("irq_before_disable", {7'b0, irq}, 8'h01);
    bus_write(3'd6, 8'h10);
    idle(1);
    check("irq_disabled", {7'b0, irq}, 8'h00);
    bus_read(3'd7, 8'h01, "status_kept");
    ack(3'd4);

    // Timer write coinciding with a tick: write wins
    bus_write(3'd6, 8'h00);
    bus_write(3'd3, 8'h05);
    idle(255);
    bus_write(3'd3, 8'h07);
    bus_read(3'd3, 8'h07, "write_beats_tick");
    idle(255);
    bus_read(3'd3, 8'h06, "tick_after_write");

    // DMA-done edge latch and set-beats-ack
    bus_write(3'd6, 8'h04);
    dma_done = 1'b1;
    idle(1);
    dma_done = 1'b0;
    bus_read(3'd7, 8'h02, "dma_status");
    check("dma_irq", {7'b0, irq}, 8'h01);
    dma_done = 1'b1;
    bus_read(3'd5, 8'h02, "dma_ack_read");
    dma_done = 1'b0;
    bus_read(3'd7, 8'h02, "dma_set_wins");
    ack(3'd5);
    bus_read(3'd7, 8'h00, "dma_ack_clears");

    // Reset returns everything to zero
    do_reset();
    check("rst2_outputs", {4'b0, irq, lcd_en, bank}, 8'h00);
    bus_read(3'd6, 8'h00, "rst2_ctl");
    bus_read(3'd7, 8'h00, "rst2_status");

`ifdef SYS_NMI_EN
    begin
      int highs;
      do_reset();
      highs = 0;
      for (int i = 0; i < 65536; i++) begin
        @(posedge clk);
        #1;
        if (nmi === 1'b1) highs++;
      end
      check("nmi_once_per_65536", 8'(highs), 8'd1);
    end
`else
    check("nmi_tied_low", {7'b0, nmi}, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

`ifndef SYS_NMI_EN
  // nmi must stay low for the whole run
  always @(negedge clk) begin
    if (nmi !== 1'b0) begin
      n_vec++;
      n_err++;
      $error("FAIL nmi_low: observed %b expected 0", nmi);
    end
  end
`endif

endmodule
